// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and memory-busy freeze.
// Optional saturating performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             i_id_uses_rt,
  input  logic             i_ex_memread,
  input  logic [4:0]       i_ex_rt,
  input  logic             i_branch_taken,
  input  logic             i_mem_busy,
  output logic             o_pc_write,
  output logic             o_ifid_write,
  output logic             o_idex_bubble,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic             o_exmem_flush,
  output logic             o_pipe_hold,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN        = 2'b00,
    S_HOLD       = 2'b01,
    S_HOLD_FLUSH = 2'b10
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_luh;
  logic   w_flush;

  assign w_luh = i_ex_memread && (i_ex_rt != 5'd0) &&
                 ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));

  // A branch seen while frozen is remembered in HOLD_FLUSH and replayed on release.
  assign w_flush = (r_state == S_HOLD_FLUSH) || i_branch_taken;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = S_RUN;
    o_pc_write    = 1'b0;
    o_ifid_write  = 1'b0;
    o_idex_bubble = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_flush  = 1'b0;
    o_exmem_flush = 1'b0;
    o_pipe_hold   = 1'b0;
    if (i_rst) begin
      w_state_nxt = S_RUN;
    end else if (i_mem_busy) begin
      o_pipe_hold = 1'b1;
      w_state_nxt = w_flush ? S_HOLD_FLUSH : S_HOLD;
    end else if (w_flush) begin
      o_ifid_flush  = 1'b1;
      o_idex_flush  = 1'b1;
      o_exmem_flush = 1'b1;
      o_pc_write    = 1'b1;
      o_ifid_write  = 1'b1;
    end else if (w_luh) begin
      o_idex_bubble = 1'b1;
    end else begin
      o_pc_write   = 1'b1;
      o_ifid_write = 1'b1;
    end
  end

  assign o_state = r_state;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (o_idex_bubble && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (o_ifid_flush && (r_flush_cnt != '1))  r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif

endmodule
